// File: rtl/amns_modexp_scheduler.sv
// Left-to-right square-and-multiply sequencer for AMNS modular exponentiation.
// Leading exponent zeros are skipped; all outputs are registered Moore decodes.
module amns_modexp_scheduler #(
  parameter int unsigned EXP_WIDTH = 16,
  localparam int unsigned CNT_WIDTH = $clog2(2*EXP_WIDTH+1)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [EXP_WIDTH-1:0] exponent_i,
  input  logic                 mm_done_i,
  output logic                 mm_start_o,
  output logic                 op_sel_o,
  output logic                 copy_base_o,
  output logic                 load_one_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] mm_count_o
);

  localparam int unsigned IDX_WIDTH = $clog2(EXP_WIDTH);

  typedef enum logic [3:0] {
    IDLE, SCAN, COPY, LOAD_ONE, SQR_START, SQR_WAIT,
    MUL_START, MUL_WAIT, NEXT, DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [EXP_WIDTH-1:0]   e_q, e_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic mm_start_q, mm_start_d;
  logic op_sel_q, op_sel_d;
  logic copy_q, copy_d;
  logic load_q, load_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state, datapath and output decode of the next state
  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          e_d     = exponent_i;
          idx_d   = IDX_WIDTH'(EXP_WIDTH - 1);
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (e_q[idx_q]) begin
          state_d = COPY;
        end else if (idx_q == '0) begin
          state_d = LOAD_ONE;
        end else begin
          idx_d = idx_q - IDX_WIDTH'(1);
        end
      end
      COPY: begin
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_WIDTH'(1);
          state_d = SQR_START;
        end
      end
      LOAD_ONE:  state_d = DONE;
      SQR_START: state_d = SQR_WAIT;
      SQR_WAIT: begin
        if (mm_done_i) state_d = e_q[idx_q] ? MUL_START : NEXT;
      end
      MUL_START: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mm_done_i) state_d = NEXT;
      end
      NEXT: begin
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IDX_WIDTH'(1);
          state_d = SQR_START;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Count rises together with the request strobe
    if (state_d == SQR_START || state_d == MUL_START) cnt_d = cnt_q + CNT_WIDTH'(1);

    mm_start_d = (state_d == SQR_START) || (state_d == MUL_START);
    op_sel_d   = (state_d == MUL_START) || (state_d == MUL_WAIT);
    copy_d     = (state_d == COPY);
    load_d     = (state_d == LOAD_ONE);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      e_q        <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      mm_start_q <= 1'b0;
      op_sel_q   <= 1'b0;
      copy_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mm_start_q <= mm_start_d;
      op_sel_q   <= op_sel_d;
      copy_q     <= copy_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mm_start_o  = mm_start_q;
  assign op_sel_o    = op_sel_q;
  assign copy_base_o = copy_q;
  assign load_one_o  = load_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mm_count_o  = cnt_q;

endmodule

// File: tb/tb_amns_modexp_scheduler.sv
// Randomized bench for amns_modexp_scheduler with a bit-level exponentiation model
// and a multiplier responder that answers each request after a chosen delay.
module tb_amns_modexp_scheduler;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(2*W+1);

  logic          clk = 1'b0;
  logic          reset_i, start_i, mm_done_i;
  logic [W-1:0]  exponent_i;
  logic          mm_start_o, op_sel_o, copy_base_o, load_one_o, busy_o, done_o;
  logic [CW-1:0] mm_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  amns_modexp_scheduler #(.EXP_WIDTH(W)) dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .exponent_i (exponent_i),
    .mm_done_i  (mm_done_i),
    .mm_start_o (mm_start_o),
    .op_sel_o   (op_sel_o),
    .copy_base_o(copy_base_o),
    .load_one_o (load_one_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .mm_count_o (mm_count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: op_sel sequence for left-to-right square-and-multiply
  task automatic model(input logic [W-1:0] e, output int nreq, output logic [31:0] seq,
                       output int scan, output int lower);
    int k;
    k = -1;
    for (int i = 0; i < int'(W); i++) if (e[i]) k = i;
    nreq = 0; seq = '0;
    scan  = (k < 0) ? int'(W) : int'(W) - k;
    lower = (k < 0) ? 0 : k;
    for (int i = k - 1; i >= 0; i--) begin
      seq = {seq[30:0], 1'b0}; nreq++;
      if (e[i]) begin seq = {seq[30:0], 1'b1}; nreq++; end
    end
  endtask

  // Run one exponentiation; delays d in [lmin,lmax] cycles of WAIT per multiply
  task automatic run_exp(input string tag, input logic [W-1:0] e, input int lmin,
                         input int lmax, input bit noise);
    int nreq_x, scan_x, lower_x;
    logic [31:0] seq_x, seq_g;
    int nreq_g, copies, loads, dones, busy_cyc, viol, sum_lat, cnt, cyc;
    bit pending, just;
    logic cur_sel;
    model(e, nreq_x, seq_x, scan_x, lower_x);
    seq_g = '0; nreq_g = 0; copies = 0; loads = 0; dones = 0; busy_cyc = 0;
    viol = 0; sum_lat = 0; cnt = 0; pending = 0; cur_sel = 1'b0;
    @(negedge clk); exponent_i = e; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0; exponent_i = W'($urandom);
    for (cyc = 0; cyc < 3000; cyc++) begin
      just = 0;
      if (busy_o) busy_cyc++;
      if (copy_base_o) copies++;
      if (load_one_o) loads++;
      if (pending && (op_sel_o !== cur_sel || mm_start_o)) viol++;
      if (mm_start_o && !pending) begin
        seq_g = {seq_g[30:0], op_sel_o}; nreq_g++;
        cur_sel = op_sel_o; pending = 1; just = 1;
        cnt = int'($urandom_range(lmax, lmin)); sum_lat += cnt;
      end
      mm_done_i = 1'b0;
      start_i = noise ? ($urandom_range(2, 0) == 0) : 1'b0;
      if (noise) exponent_i = W'($urandom);
      if (done_o) begin
        dones++;
        break;
      end
      if (pending && !just) begin
        if (cnt == 1) begin mm_done_i = 1'b1; pending = 0; end
        else cnt--;
      end else if (!pending && noise && $urandom_range(3, 0) == 0) begin
        mm_done_i = 1'b1;
      end
      @(negedge clk);
    end
    check({tag, " timeout"}, 32'(cyc < 3000), 32'd1);
    check({tag, " nreq"}, 32'(nreq_g), 32'(nreq_x));
    check({tag, " op_sel seq"}, seq_g, seq_x);
    check({tag, " mm_count"}, 32'(mm_count_o), 32'(nreq_x));
    check({tag, " copy"}, 32'(copies), (e == '0) ? 32'd0 : 32'd1);
    check({tag, " load_one"}, 32'(loads), (e == '0) ? 32'd1 : 32'd0);
    check({tag, " done"}, 32'(dones), 32'd1);
    check({tag, " op_sel stable"}, 32'(viol), 32'd0);
    check({tag, " busy cycles"}, 32'(busy_cyc),
          (e == '0) ? 32'(W + 2) : 32'(scan_x + 2 + lower_x + nreq_x + sum_lat));
    // start_i may be high here; the DONE cycle must not accept it
    @(negedge clk);
    start_i = 1'b0; mm_done_i = 1'b0;
    check({tag, " idle after"}, {30'd0, busy_o, done_o}, 32'd0);
    check({tag, " count held"}, 32'(mm_count_o), 32'(nreq_x));
  endtask

  initial begin
    int guard, stray;
    reset_i = 1'b1; start_i = 1'b0; mm_done_i = 1'b0; exponent_i = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {25'd0, mm_start_o, op_sel_o, copy_base_o, load_one_o,
                            busy_o, done_o, 1'b0} | 32'(mm_count_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    run_exp("e00", 8'h00, 1, 1, 0);
    run_exp("e01", 8'h01, 1, 1, 0);
    run_exp("eB5", 8'hB5, 5, 5, 0);
    run_exp("eFF", 8'hFF, 1, 6, 1);
    run_exp("e80", 8'h80, 1, 4, 0);

    // Abort in SQR_WAIT, then a stale completion must be ignored
    @(negedge clk); exponent_i = 8'h40; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    guard = 0;
    while (!mm_start_o && guard < 50) begin @(negedge clk); guard++; end
    check("abort reach start", 32'(guard < 50), 32'd1);
    @(negedge clk);
    check("abort in wait", {30'd0, busy_o, op_sel_o}, 32'd2);
    reset_i = 1'b1;
    @(negedge clk);
    check("abort outputs", {25'd0, mm_start_o, op_sel_o, copy_base_o, load_one_o,
                            busy_o, done_o, 1'b0} | 32'(mm_count_o), 32'd0);
    reset_i = 1'b0; mm_done_i = 1'b1;
    @(negedge clk); mm_done_i = 1'b0;
    stray = 0;
    repeat (6) begin
      if (mm_start_o || busy_o || done_o) stray++;
      @(negedge clk);
    end
    check("late done ignored", 32'(stray), 32'd0);
    run_exp("e03", 8'h03, 1, 3, 0);

    for (int r = 0; r < 20; r++) run_exp("rand", W'($urandom), 1, 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
